// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - constants shared by the decoder receive and serializer sides
package decoder_pkg;
   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - modulo-WIDTH bit position counter with frame sync load
module frame_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          inc,
   input  logic          sync,
   output logic [CW-1:0] count,
   output logic          wrap
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      wrap    = 1'b0;
      count_d = count_q;
      if (inc) begin
         // A sync bit is the first bit of a word, so it only completes one when WIDTH is 1.
         if (sync) begin
            wrap = (WIDTH == 1);
         end else begin
            wrap = (count_q == CW'(WIDTH - 1));
         end
         if (wrap) begin
            count_d = '0;
         end else if (sync) begin
            count_d = CW'(1);
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out word assembler with one-entry output buffer
module sipo_deserializer
   import decoder_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1,
   parameter int CW        = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             serialIn,
   input  logic             bitValid,
   input  logic             frameSync,
   output logic [WIDTH-1:0] wordData,
   output logic             wordValid,
   input  logic             wordReady,
   output logic             overrun,
   input  logic             clearOverrun,
   output logic             syncErr,
   output logic [CW-1:0]    bitCount
);

   logic [WIDTH-1:0] shifter_q, shifter_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             sync_err_q, sync_err_d;

   logic [WIDTH-1:0] shift_base;
   logic [WIDTH-1:0] word_next;
   logic [CW-1:0]    count;
   logic             wrap;
   logic             candidate;
   logic             load;

   frame_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (bitValid),
      .sync    (frameSync),
      .count   (count),
      .wrap    (wrap)
   );

   always_comb begin
      shift_base = frameSync ? '0 : shifter_q;
      if (MSB_FIRST != 0) begin
         word_next = (shift_base << 1) | WIDTH'(serialIn);
      end else begin
         word_next = (shift_base >> 1) | (WIDTH'(serialIn) << (WIDTH - 1));
      end

      candidate = bitValid && wrap;
      // A consumer taking the held word in the same cycle frees the slot for the new one.
      load      = candidate && (!valid_q || wordReady);

      shifter_d = shifter_q;
      if (bitValid) begin
         shifter_d = wrap ? '0 : word_next;
      end

      data_d  = data_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = word_next;
         valid_d = 1'b1;
      end else if (valid_q && wordReady) begin
         valid_d = 1'b0;
      end

      overrun_d = overrun_q;
      if (candidate && !load) begin
         overrun_d = 1'b1;
      end else if (clearOverrun) begin
         overrun_d = 1'b0;
      end

      sync_err_d = bitValid && frameSync && (count != '0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shifter_q  <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         shifter_q  <= shifter_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign wordData  = data_q;
   assign wordValid = valid_q;
   assign overrun   = overrun_q;
   assign syncErr   = sync_err_q;
   assign bitCount  = count;

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Parametrised serial-in/parallel-out deserializer for the decoder receive path. Serial bits arrive qualified by `bitValid`; `frameSync` realigns word boundaries. Each completed WIDTH-bit word is presented on a one-entry valid/ready output buffer. Sync misalignment and buffer overrun are reported.

Parameters:
WIDTH, 8, bits per word; legal range 1..32.
MSB_FIRST, 1, 1: first received bit lands in wordData[WIDTH-1]; 0: first bit lands in wordData[0].
CW, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
serialIn  in  1  serial data bit
bitValid  in  1  serialIn is sampled this cycle
frameSync  in  1  qualified by bitValid; this bit is bit 0 of a new word
wordData  out  WIDTH  assembled word; stable while wordValid=1
wordValid  out  1  output buffer holds an unconsumed word
wordReady  in  1  consumer accepts wordData when wordValid&&wordReady
overrun  out  1  sticky: a completed word was dropped because the buffer was full
clearOverrun  in  1  synchronous clear of overrun
syncErr  out  1  one-cycle pulse: frameSync arrived with a partial word pending
bitCount  out  CW  bits accepted into the current partial word, 0..WIDTH-1

Behaviour:
- Reset (async assert, sync release): shifter=0, bitCount=0, wordData=0, wordValid=0, overrun=0, syncErr=0.
- Idle cycles (bitValid=0): shifter and bitCount hold. Only the output-buffer handshake and clearOverrun act.
- Accepted bit, frameSync=0: bit enters the shifter and bitCount increments.
  - MSB_FIRST=1: shift left, new bit into LSB.
  - MSB_FIRST=0: shift right, new bit into MSB.
- Accepted bit, frameSync=1:
  - Partial word discarded; the bit becomes the first bit of a new word; bitCount=1.
  - syncErr pulses next cycle only if bitCount!=0 before this bit.
- Word completion: an accepted bit with bitCount==WIDTH-1 (or frameSync with WIDTH=1) completes the word.
  - bitCount returns to 0.
  - The completed word, including this bit, is the transfer candidate.
- Buffer load: the candidate loads wordData and sets wordValid at the same clock edge, so the word is visible the cycle after its last bit. This happens if wordValid=0, or if wordValid&&wordReady in the same cycle (pass-through; no bubble).
- Buffer full: otherwise the candidate is dropped, wordData is unchanged, and overrun sets.
- Consume: wordValid&&wordReady with no new candidate clears wordValid. wordData keeps its last value.
- wordReady while wordValid=0 has no effect.
- overrun:
  - Cleared by clearOverrun.
  - If a set and clearOverrun coincide, the set wins.
  - Independent of further traffic.
- Reset asserted mid-word or with a pending word: everything is lost immediately. The first bit after release starts a fresh word even without frameSync.
- Back-to-back words at one bit per cycle sustain full throughput when wordReady=1.

Decomposition:
- Package `decoder_pkg`: no typedefs required; holds the default WIDTH constant shared with the serializer side.
- One sub-module, `frame_bit_counter`. It is a parametrised modulo-WIDTH counter with inputs inc and sync (sync loads 1) and outputs count and wrap (combinational, high when the increment completes a word).
- Shifter, output buffer and flags live in the top.

Test Plan:
- Basic MSB-first word: WIDTH=8, MSB_FIRST=1, wordReady=1. Bits 1,0,1,0,0,1,0,1 (frameSync on the first) -> wordValid=1 for exactly one cycle, starting the cycle after the 8th bit; wordData=8'hA5; syncErr=0.
- LSB-first mode: MSB_FIRST=0. Bits 0,1,0,0,1,0,0,0 -> wordData=8'h12. The same bits with MSB_FIRST=1 -> 8'h48.
- Backpressure and overrun: wordReady=0, two consecutive words 8'h11 then 8'h22 -> wordData stays 8'h11, overrun=1. Then wordReady=1 for one cycle -> wordValid=0. Then clearOverrun=1 -> overrun=0.
- Pass-through: buffer holds 8'h33, and wordReady=1 in the same cycle the next word 8'h44 completes -> wordValid stays 1 with no bubble; wordData=8'h44; overrun=0.
- Resync: 3 bits sent, then frameSync with bits of 8'hC3 -> syncErr single pulse; the next word is 8'hC3; bitCount was 3 before the sync.
- Reset mid-word: 5 bits sent, reset_n pulsed low asynchronously (between clock edges) -> all outputs 0 immediately. Then 8 bits of 8'h5A without frameSync -> wordData=8'h5A.
